// File: rtl/modulation_config_scheduler_if.sv
// Config offer channel from the CPU-side controller to the scheduler.
// VALID/READY: a transfer happens on a rising edge where both are high; the sender holds VALID and data until then.
interface modulation_config_scheduler_if;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [15:0] CFG_CYCLE;
    logic [31:0] CFG_FREQ_DIV;
    logic        CFG_FORCE;

    modport master (
        output CFG_VALID,
        output CFG_CYCLE,
        output CFG_FREQ_DIV,
        output CFG_FORCE,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_CYCLE,
        input  CFG_FREQ_DIV,
        input  CFG_FORCE,
        output CFG_READY
    );
endinterface

// File: rtl/modulation_config_scheduler.sv
// Holds the live modulation config and swaps in a validated shadow copy atomically,
// either at a modulation period boundary (IDX wraps to 0) or immediately when forced.
module modulation_config_scheduler #(
    parameter logic [15:0] CYCLE_LIMIT      = 16'd32767,
    parameter logic [31:0] MIN_FREQ_DIV     = 32'd512,
    parameter logic [15:0] DEFAULT_CYCLE    = 16'd1,
    parameter logic [31:0] DEFAULT_FREQ_DIV = 32'd40960
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    modulation_config_scheduler_if.slave        cfg,
    input  logic [15:0]                         IDX,
    input  logic                                ERR_CLR,
    output logic [15:0]                         CYCLE_M,
    output logic [31:0]                         FREQ_DIV_M,
    output logic                                UPDATE,
    output logic                                PENDING,
    output logic                                ERR,
    output logic [7:0]                          UPDATE_CNT,
    output logic [1:0]                          dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        ready_q, ready_d;
    logic [15:0] sh_cycle_q, sh_cycle_d;
    logic [31:0] sh_div_q, sh_div_d;
    logic        sh_force_q, sh_force_d;
    logic [15:0] cycle_q, cycle_d;
    logic [31:0] div_q, div_d;
    logic        update_q, update_d;
    logic        pending_q, pending_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] idx_prev_q, idx_prev_d;

    logic handshake;
    logic legal;
    logic boundary;
    logic err_set;

    assign handshake = cfg.CFG_VALID && ready_q;
    assign legal     = (sh_cycle_q <= CYCLE_LIMIT) && (sh_div_q >= MIN_FREQ_DIV);
    // A zero-length period wraps every cycle, so any IDX==0 counts as a boundary.
    assign boundary  = (IDX == 16'd0) && ((cycle_q == 16'd0) || (idx_prev_q == cycle_q));

    always_comb begin
        state_d    = state_q;
        sh_cycle_d = sh_cycle_q;
        sh_div_d   = sh_div_q;
        sh_force_d = sh_force_q;
        cycle_d    = cycle_q;
        div_d      = div_q;
        update_d   = 1'b0;
        pending_d  = pending_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        idx_prev_d = IDX;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    sh_cycle_d = cfg.CFG_CYCLE;
                    sh_div_d   = cfg.CFG_FREQ_DIV;
                    sh_force_d = cfg.CFG_FORCE;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (legal) begin
                    pending_d = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (boundary || sh_force_q) begin
                    cycle_d   = sh_cycle_q;
                    div_d     = sh_div_q;
                    update_d  = 1'b1;
                    pending_d = 1'b0;
                    cnt_d     = cnt_q + 8'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A rejection landing in the same cycle as ERR_CLR must stay visible.
        err_d   = err_set ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            sh_cycle_q <= 16'd0;
            sh_div_q   <= 32'd0;
            sh_force_q <= 1'b0;
            cycle_q    <= DEFAULT_CYCLE;
            div_q      <= DEFAULT_FREQ_DIV;
            update_q   <= 1'b0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
            idx_prev_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            sh_cycle_q <= sh_cycle_d;
            sh_div_q   <= sh_div_d;
            sh_force_q <= sh_force_d;
            cycle_q    <= cycle_d;
            div_q      <= div_d;
            update_q   <= update_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            idx_prev_q <= idx_prev_d;
        end
    end

    assign cfg.CFG_READY = ready_q;
    assign CYCLE_M       = cycle_q;
    assign FREQ_DIV_M    = div_q;
    assign UPDATE        = update_q;
    assign PENDING       = pending_q;
    assign ERR           = err_q;
    assign UPDATE_CNT    = cnt_q;
    assign dbg_state     = state_q;

endmodule
